// File: rtl/parity_stream_using_mux.sv
// parity_stream_using_mux
// Streaming frame-parity engine. Each WIDTH-bit word is folded to one parity
// bit by a balanced tree of 2:1 mux XOR cells (stage 1), then accumulated
// across the frame together with a saturating word count (stage 2). The
// frame result is published on the cycle after the last word leaves stage 1.

// Basic 2:1 multiplexer cell; every XOR in the datapath is built from one.
module parity_stream_using_mux_cell (
   input  logic sel,
   input  logic d0,
   input  logic d1,
   output logic y
);
   assign y = sel ? d1 : d0;
endmodule

// Two-input XOR made from a mux: a selects between b and its complement.
module parity_stream_using_mux_xor (
   input  logic a,
   input  logic b,
   output logic y
);
   logic b_n;

   assign b_n = ~b;

   parity_stream_using_mux_cell u_cell (
      .sel (a),
      .d0  (b),
      .d1  (b_n),
      .y   (y)
   );
endmodule

// Recursive XOR-reduction tree. The word is split into a lower half of
// WIDTH/2 bits and an upper half holding the remainder, so any WIDTH works
// and the depth stays ceil(log2(WIDTH)). A single bit passes straight through.
module parity_stream_using_mux_tree #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   output logic             par
);
   generate
      if (WIDTH == 1) begin : g_leaf
         assign par = data[0];
      end else begin : g_split
         localparam int LO_W = WIDTH / 2;
         localparam int HI_W = WIDTH - LO_W;

         logic lo_par;
         logic hi_par;

         parity_stream_using_mux_tree #(.WIDTH(LO_W)) u_lo (
            .data (data[LO_W-1:0]),
            .par  (lo_par)
         );

         parity_stream_using_mux_tree #(.WIDTH(HI_W)) u_hi (
            .data (data[WIDTH-1:LO_W]),
            .par  (hi_par)
         );

         parity_stream_using_mux_xor u_xor (
            .a (lo_par),
            .b (hi_par),
            .y (par)
         );
      end
   endgenerate
endmodule

// Top level: two-stage pipeline, registered outputs only.
module parity_stream_using_mux #(
   parameter int WIDTH   = 8,
   parameter int ODD     = 0,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_last,
   output logic               out_valid,
   output logic               out_parity,
   output logic [COUNT_W-1:0] out_words
);
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
   localparam logic               ODD_BIT = (ODD != 0);

   // Stage 1 registers
   logic s1_valid_q, s1_valid_d;
   logic s1_par_q,   s1_par_d;
   logic s1_last_q,  s1_last_d;

   // Stage 2 registers
   logic               acc_q,        acc_d;
   logic [COUNT_W-1:0] cnt_q,        cnt_d;
   logic               out_valid_q,  out_valid_d;
   logic               out_parity_q, out_parity_d;
   logic [COUNT_W-1:0] out_words_q,  out_words_d;

   // Combinational helpers
   logic               word_par;
   logic               acc_par;
   logic               frame_par;
   logic               odd_bit;
   logic [COUNT_W-1:0] cnt_inc;

   assign odd_bit = ODD_BIT;

   parity_stream_using_mux_tree #(.WIDTH(WIDTH)) u_tree (
      .data (in_data),
      .par  (word_par)
   );

   // Running parity of the frame including the word now in stage 1.
   parity_stream_using_mux_xor u_acc_xor (
      .a (acc_q),
      .b (s1_par_q),
      .y (acc_par)
   );

   // Final polarity adjustment for odd-parity instances.
   parity_stream_using_mux_xor u_odd_xor (
      .a (acc_par),
      .b (odd_bit),
      .y (frame_par)
   );

   // Counter increment that sticks at all-ones instead of wrapping.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_W'(1);

   // Stage 1 next state: capture qualifier and the word's folded parity.
   always_comb begin
      s1_valid_d = in_valid;
      s1_par_d   = word_par;
      s1_last_d  = in_last;
   end

   // Stage 2 next state: accumulate mid-frame words, publish and clear on last.
   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = 1'b0;
      out_parity_d = out_parity_q;
      out_words_d  = out_words_q;
      if (s1_valid_q) begin
         if (s1_last_q) begin
            out_parity_d = frame_par;
            out_words_d  = cnt_inc;
            out_valid_d  = 1'b1;
            acc_d        = 1'b0;
            cnt_d        = '0;
         end else begin
            acc_d = acc_par;
            cnt_d = cnt_inc;
         end
      end
   end

   // All state registers; reset abandons any frame and flushes the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_par_q     <= 1'b0;
         s1_last_q    <= 1'b0;
         acc_q        <= 1'b0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_parity_q <= 1'b0;
         out_words_q  <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_par_q     <= s1_par_d;
         s1_last_q    <= s1_last_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_parity_q <= out_parity_d;
         out_words_q  <= out_words_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_parity = out_parity_q;
   assign out_words  = out_words_q;
endmodule

// File: tb/tb_parity_stream_using_mux.sv
// tb_parity_stream_using_mux
// Directed vector table plus hand-written multi-cycle sequences on 8-bit
// instances (even, odd, 2-bit counter), then random frames on widths 1/5/8/13
// checked every cycle against a reference model with a 2-cycle delay line.

module tb_parity_stream_using_mux;

   typedef struct {
      logic        v;
      logic        l;
      logic [7:0]  d;
      logic        e_v;
      logic        e_p;
      logic [15:0] e_w;
   } vec_t;

   localparam int NVEC = 35;
   localparam int WS   [4] = '{1, 5, 8, 13};
   localparam bit ODDS [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   localparam int MAXC [4] = '{255, 255, 255, 7};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic [15:0] in_data;

   logic       ov8, op8, ovo, opo, ovs, ops, ov1, op1, ov5, op5, ov13, op13;
   logic [7:0] ow8, owo, ow1, ow5;
   logic [1:0] ows;
   logic [2:0] ow13;

   int vec_count   = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit sb_en       = 1'b0;

   logic        exp_v [4][4];
   logic        exp_p [4][4];
   logic [15:0] exp_w [4][4];
   logic        hold_p [4];
   logic [15:0] hold_w [4];
   logic        m_acc  [4];
   int          m_cnt  [4];
   logic        av [4];
   logic        ap [4];
   logic [15:0] aw [4];

   vec_t tbl [NVEC];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   parity_stream_using_mux #(.WIDTH(8), .ODD(0), .COUNT_W(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[7:0]),
      .in_last(in_last), .out_valid(ov8), .out_parity(op8), .out_words(ow8));

   parity_stream_using_mux #(.WIDTH(8), .ODD(1), .COUNT_W(8)) u_odd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[7:0]),
      .in_last(in_last), .out_valid(ovo), .out_parity(opo), .out_words(owo));

   parity_stream_using_mux #(.WIDTH(8), .ODD(0), .COUNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[7:0]),
      .in_last(in_last), .out_valid(ovs), .out_parity(ops), .out_words(ows));

   parity_stream_using_mux #(.WIDTH(1), .ODD(0), .COUNT_W(8)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[0:0]),
      .in_last(in_last), .out_valid(ov1), .out_parity(op1), .out_words(ow1));

   parity_stream_using_mux #(.WIDTH(5), .ODD(1), .COUNT_W(8)) u_w5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[4:0]),
      .in_last(in_last), .out_valid(ov5), .out_parity(op5), .out_words(ow5));

   parity_stream_using_mux #(.WIDTH(13), .ODD(0), .COUNT_W(3)) u_w13 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[12:0]),
      .in_last(in_last), .out_valid(ov13), .out_parity(op13), .out_words(ow13));

   function automatic vec_t mk(input logic v, input logic l, input logic [7:0] d,
                               input logic ev, input logic ep, input int ew);
      vec_t r;
      r.v   = v;
      r.l   = l;
      r.d   = d;
      r.e_v = ev;
      r.e_p = ep;
      r.e_w = 16'(ew);
      return r;
   endfunction

   function automatic logic par_w(input logic [15:0] d, input int w);
      logic [15:0] m;
      m = 16'((32'd1 << w) - 1);
      return ^(d & m);
   endfunction

   task automatic apply_stimulus(input logic v, input logic l, input logic [15:0] d);
      in_valid = v;
      in_last  = l;
      in_data  = d;
   endtask

   task automatic check_output(input string name,
                               input logic av_i, input logic ap_i, input logic [15:0] aw_i,
                               input logic ev_i, input logic ep_i, input logic [15:0] ew_i);
      vec_count++;
      if (av_i !== ev_i || ap_i !== ep_i || aw_i !== ew_i) begin
         miscompares++;
         $display("[TB] FAIL %s @%0t: got valid=%b parity=%b words=%0d, want valid=%b parity=%b words=%0d",
                  name, $time, av_i, ap_i, aw_i, ev_i, ep_i, ew_i);
      end
   endtask

   // One random-phase cycle: drive inputs and schedule the model's result two cycles ahead.
   task automatic rnd_cycle(input logic v, input logic l, input logic [15:0] d);
      int  slot;
      logic p;
      int  nc;
      @(negedge clk);
      apply_stimulus(v, l, d);
      slot = (cyc + 2) % 4;
      for (int i = 0; i < 4; i++) begin
         exp_v[i][slot] = 1'b0;
         if (v) begin
            p  = par_w(d, WS[i]);
            nc = (m_cnt[i] + 1 > MAXC[i]) ? MAXC[i] : m_cnt[i] + 1;
            if (l) begin
               exp_v[i][slot] = 1'b1;
               exp_p[i][slot] = m_acc[i] ^ p ^ ODDS[i];
               exp_w[i][slot] = 16'(nc);
               m_acc[i]       = 1'b0;
               m_cnt[i]       = 0;
            end else begin
               m_acc[i] = m_acc[i] ^ p;
               m_cnt[i] = nc;
            end
         end
      end
   endtask

   // Random-phase scoreboard: every cycle compare all four instances to the model.
   always @(negedge clk) begin
      if (sb_en) begin
         int s;
         s  = cyc % 4;
         av = '{ov1, ov5, ov8, ov13};
         ap = '{op1, op5, op8, op13};
         aw = '{16'(ow1), 16'(ow5), 16'(ow8), 16'(ow13)};
         for (int i = 0; i < 4; i++) begin
            if (exp_v[i][s] === 1'b1) begin
               hold_p[i] = exp_p[i][s];
               hold_w[i] = exp_w[i][s];
            end
            check_output($sformatf("rnd_w%0d", WS[i]), av[i], ap[i], aw[i],
                         exp_v[i][s], hold_p[i], hold_w[i]);
         end
      end
   end

   initial begin
      // Row j expects the outputs produced by the inputs of row j-2.
      tbl[0]  = mk(1, 1, 8'hA5, 0, 0, 0);
      tbl[1]  = mk(0, 0, 8'h00, 0, 0, 0);
      tbl[2]  = mk(0, 0, 8'h00, 1, 0, 1);
      tbl[3]  = mk(0, 0, 8'h00, 0, 0, 1);
      tbl[4]  = mk(1, 0, 8'h01, 0, 0, 1);
      tbl[5]  = mk(0, 0, 8'h00, 0, 0, 1);
      tbl[6]  = mk(1, 0, 8'h03, 0, 0, 1);
      tbl[7]  = mk(0, 0, 8'h00, 0, 0, 1);
      tbl[8]  = mk(0, 0, 8'h00, 0, 0, 1);
      tbl[9]  = mk(1, 1, 8'h07, 0, 0, 1);
      tbl[10] = mk(0, 0, 8'h00, 0, 0, 1);
      tbl[11] = mk(0, 0, 8'h00, 1, 0, 3);
      tbl[12] = mk(1, 0, 8'h01, 0, 0, 3);
      tbl[13] = mk(0, 0, 8'h00, 0, 0, 3);
      tbl[14] = mk(1, 0, 8'h03, 0, 0, 3);
      tbl[15] = mk(0, 0, 8'h00, 0, 0, 3);
      tbl[16] = mk(0, 0, 8'h00, 0, 0, 3);
      tbl[17] = mk(1, 1, 8'h06, 0, 0, 3);
      tbl[18] = mk(0, 0, 8'h00, 0, 0, 3);
      tbl[19] = mk(0, 0, 8'h00, 1, 1, 3);
      tbl[20] = mk(1, 1, 8'h01, 0, 1, 3);
      tbl[21] = mk(1, 1, 8'h80, 0, 1, 3);
      tbl[22] = mk(1, 1, 8'h00, 1, 1, 1);
      tbl[23] = mk(0, 0, 8'h00, 1, 1, 1);
      tbl[24] = mk(0, 0, 8'h00, 1, 0, 1);
      tbl[25] = mk(0, 0, 8'h00, 0, 0, 1);
      tbl[26] = mk(0, 1, 8'hFF, 0, 0, 1);
      tbl[27] = mk(1, 0, 8'hFF, 0, 0, 1);
      tbl[28] = mk(0, 1, 8'h00, 0, 0, 1);
      tbl[29] = mk(1, 1, 8'h80, 0, 0, 1);
      tbl[30] = mk(1, 0, 8'h03, 0, 0, 1);
      tbl[31] = mk(1, 1, 8'h01, 1, 1, 2);
      tbl[32] = mk(0, 0, 8'h00, 0, 1, 2);
      tbl[33] = mk(0, 0, 8'h00, 1, 1, 2);
      tbl[34] = mk(0, 0, 8'h00, 0, 1, 2);

      // Reset held for two edges while a valid last word is offered.
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b1, 16'h00FF);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_output("reset_w8",  ov8, op8, 16'(ow8), 1'b0, 1'b0, 16'd0);
         check_output("reset_odd", ovo, opo, 16'(owo), 1'b0, 1'b0, 16'd0);
      end
      rst = 1'b0;
      apply_stimulus(1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_output("post_reset_w8",  ov8, op8, 16'(ow8), 1'b0, 1'b0, 16'd0);
         check_output("post_reset_sat", ovs, ops, 16'(ows), 1'b0, 1'b0, 16'd0);
      end

      // Vector table on the even 8-bit instance.
      for (int j = 0; j < NVEC; j++) begin
         @(negedge clk);
         check_output($sformatf("tbl_row%0d", j), ov8, op8, 16'(ow8),
                      tbl[j].e_v, tbl[j].e_p, tbl[j].e_w);
         apply_stimulus(tbl[j].v, tbl[j].l, {8'h00, tbl[j].d});
      end

      // Reset mid-frame; a word offered during reset is discarded too.
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 16'h0001);
      @(negedge clk);
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 16'h0001);
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1'b1, 1'b1, 16'h0002);
      @(negedge clk);
      check_output("rst_mid_wait", ov8, op8, 16'(ow8), 1'b0, 1'b0, 16'd0);
      apply_stimulus(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check_output("rst_mid_result", ov8, op8, 16'(ow8), 1'b1, 1'b1, 16'd1);
      @(negedge clk);
      check_output("rst_mid_hold", ov8, op8, 16'(ow8), 1'b0, 1'b1, 16'd1);

      // Odd-parity instance on an all-zero single-word frame.
      @(negedge clk);
      apply_stimulus(1'b1, 1'b1, 16'h0000);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check_output("odd_zero",      ovo, opo, 16'(owo), 1'b1, 1'b1, 16'd1);
      check_output("even_zero",     ov8, op8, 16'(ow8), 1'b1, 1'b0, 16'd1);
      @(negedge clk);
      check_output("odd_zero_hold", ovo, opo, 16'(owo), 1'b0, 1'b1, 16'd1);

      // Five-word frame: 2-bit counter saturates at 3, 8-bit counter reads 5.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         apply_stimulus(1'b1, (k == 4), 16'h0001);
      end
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check_output("sat_cw2",     ovs, ops, 16'(ows), 1'b1, 1'b1, 16'd3);
      check_output("sat_cw8",     ov8, op8, 16'(ow8), 1'b1, 1'b1, 16'd5);
      @(negedge clk);
      check_output("sat_cw2_hold", ovs, ops, 16'(ows), 1'b0, 1'b1, 16'd3);

      // Random frames across widths 1, 5, 8, 13.
      @(negedge clk);
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hold_p[i] = 1'b0;
         hold_w[i] = 16'd0;
         m_acc[i]  = 1'b0;
         m_cnt[i]  = 0;
         for (int s = 0; s < 4; s++) begin
            exp_v[i][s] = 1'b0;
            exp_p[i][s] = 1'b0;
            exp_w[i][s] = 16'd0;
         end
      end
      sb_en = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) begin
               int gaps;
               gaps = $urandom_range(1, 2);
               for (int g = 0; g < gaps; g++)
                  rnd_cycle(1'b0, 1'($urandom), 16'($urandom));
            end
            rnd_cycle(1'b1, (j == len - 1), 16'($urandom));
         end
      end
      for (int k = 0; k < 4; k++)
         rnd_cycle(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      sb_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
